regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file for the RISC-V core: NUM_RD registered read ports,
//  two write ports (WB of two pipes), hardware clear sequencer replacing the simulation-only initial block.

---
 rtl/regfile_mp_pkg.sv | 11 +
 rtl/rf_clear_seq.sv | 58 +++++
 rtl/regfile_mp.sv | 88 ++++++++
 tb/tb_regfile_mp.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared types and limits for the multi-port integer register file.
package regfile_mp_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    localparam int RF_MAX_RD = 4;

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks every register entry once, writing zero,
// after reset or on request.
module rf_clear_seq
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    rf_state_t         r_state;
    logic              r_busy;
    logic [ADDR_W-1:0] r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RF_CLEAR;
            r_busy  <= 1'b1;
            r_idx   <= '0;
        end else begin
            unique case (r_state)
                RF_IDLE: begin
                    if (clear_req) begin
                        r_state <= RF_CLEAR;
                        r_busy  <= 1'b1;
                        r_idx   <= '0;
                    end
                end
                RF_CLEAR: begin
                    // clear_req is deliberately ignored while clearing
                    if (r_idx == LAST) begin
                        r_state <= RF_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= RF_CLEAR;
                    r_busy  <= 1'b1;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign clr_we  = r_busy;
    assign clr_idx = r_idx;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NUM_RD registered read ports,
// two write ports with write-first bypass, hardware clear sequencer.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_req,
    output logic                     busy,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_idx;
    logic              w_we0;
    logic              w_we1;

    rf_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .busy      (w_busy),
        .clr_we    (w_clr_we),
        .clr_idx   (w_clr_idx)
    );

    assign busy = w_busy;

    // Effective enables: x0 writes are discarded before they reach the array or bypass
    assign w_we0 = wr0_en && !w_busy
                && !((ZERO_REG != 0) && (wr0_addr == '0));
    assign w_we1 = wr1_en && !w_busy
                && !((ZERO_REG != 0) && (wr1_addr == '0));

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_idx] <= '0;
        end else begin
            if (w_we0) r_mem[wr0_addr] <= wr0_data;
            if (w_we1) r_mem[wr1_addr] <= wr1_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_next;
        logic [DATA_W-1:0] r_data;

        assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            w_next = r_mem[w_addr];
            if ((ZERO_REG != 0) && (w_addr == '0))
                w_next = '0;
            else if (w_we1 && (wr1_addr == w_addr))
                w_next = wr1_data;
            else if (w_we0 && (wr0_addr == w_addr))
                w_next = wr0_data;
        end

        always_ff @(posedge clk) begin
            if (rst || w_busy) r_data <= '0;
            else               r_data <= w_next;
        end

        assign rd_data[k*DATA_W +: DATA_W] = r_data;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: vector table plus clear/reset sequences.
module tb_regfile_mp;

    logic         clk = 1'b0;
    logic         rst;
    logic         clear_req;
    logic         busy;
    logic         busy_z;
    logic [19:0]  rd_addr;
    logic [127:0] rd_data;
    logic [127:0] rd_data_z;
    logic         wr0_en;
    logic [4:0]   wr0_addr;
    logic [31:0]  wr0_data;
    logic         wr1_en;
    logic [4:0]   wr1_addr;
    logic [31:0]  wr1_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data)
    );

    regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(0)
    ) dut_z (
        .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_z),
        .rd_addr(rd_addr), .rd_data(rd_data_z),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data)
    );

    typedef struct packed {
        logic             we0;
        logic [4:0]       a0;
        logic [31:0]      d0;
        logic             we1;
        logic [4:0]       a1;
        logic [31:0]      d1;
        logic [3:0][4:0]  ra;
        logic [3:0][31:0] ex;
    } vec_t;

    vec_t vt [11];

    function automatic vec_t mk(
        logic we0, logic [4:0] a0, logic [31:0] d0,
        logic we1, logic [4:0] a1, logic [31:0] d1,
        logic [4:0] r0, logic [4:0] r1, logic [4:0] r2, logic [4:0] r3,
        logic [31:0] e0, logic [31:0] e1, logic [31:0] e2, logic [31:0] e3);
        vec_t v;
        v.we0 = we0; v.a0 = a0; v.d0 = d0;
        v.we1 = we1; v.a1 = a1; v.d1 = d1;
        v.ra  = {r3, r2, r1, r0};
        v.ex  = {e3, e2, e1, e0};
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_wr();
        wr0_en = 0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 0; wr1_addr = '0; wr1_data = '0;
    endtask

    // Counts cycles with busy high; a stuck busy yields 100 and fails the check
    task automatic count_busy(output int c, input bit poke_req);
        c = 0;
        while (busy && c < 100) begin
            c++;
            clear_req = poke_req && (c == 5);
            step();
        end
        clear_req = 0;
    endtask

    initial begin
        int c;
        rst = 0; clear_req = 0; rd_addr = '0;
        idle_wr();

        vt[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0);
        vt[1]  = mk(0, 0, 0, 0, 0, 0, 5, 5, 0, 0,
                    32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        vt[2]  = mk(1, 7, 32'h22, 1, 7, 32'h11, 5, 7, 7, 0,
                    32'hDEADBEEF, 32'h11, 32'h11, 0);
        vt[3]  = mk(0, 0, 0, 0, 0, 0, 7, 7, 5, 7,
                    32'h11, 32'h11, 32'hDEADBEEF, 32'h11);
        vt[4]  = mk(1, 1, 32'h101, 1, 2, 32'h202, 1, 2, 3, 4,
                    32'h101, 32'h202, 0, 0);
        vt[5]  = mk(1, 3, 32'h303, 1, 4, 32'h404, 1, 2, 3, 4,
                    32'h101, 32'h202, 32'h303, 32'h404);
        vt[6]  = mk(1, 2, 32'hA2, 1, 4, 32'hB4, 1, 2, 3, 4,
                    32'h101, 32'hA2, 32'h303, 32'hB4);
        vt[7]  = mk(0, 0, 0, 0, 0, 0, 4, 3, 2, 1,
                    32'hB4, 32'h303, 32'hA2, 32'h101);
        vt[8]  = mk(1, 9, 32'h99, 1, 0, 32'h12345678, 0, 9, 9, 0,
                    0, 32'h99, 32'h99, 0);
        vt[9]  = mk(1, 9, 32'h9A, 0, 9, 32'hFF, 9, 1, 1, 9,
                    32'h9A, 32'h101, 32'h101, 32'h9A);
        vt[10] = mk(0, 0, 0, 0, 0, 0, 9, 8, 0, 7,
                    32'h9A, 0, 0, 32'h11);

        // Reset and initial clear
        step();
        rst = 1;
        step();
        rst = 0;
        chk("reset_busy", 32'(busy), 1);
        chk("reset_rd0", rd_data[31:0], 0);
        chk("reset_rd3", rd_data[127:96], 0);
        count_busy(c, 0);
        chk("reset_clear_len", c, 32);

        for (int a = 0; a < 32; a += 4) begin
            rd_addr = {5'(a + 3), 5'(a + 2), 5'(a + 1), 5'(a)};
            step();
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("cleared_a%0d", a + k),
                    rd_data_z[k*32 +: 32], 0);
            end
        end

        // Vector table
        for (int i = 0; i < 11; i++) begin
            wr0_en = vt[i].we0; wr0_addr = vt[i].a0; wr0_data = vt[i].d0;
            wr1_en = vt[i].we1; wr1_addr = vt[i].a1; wr1_data = vt[i].d1;
            rd_addr = vt[i].ra;
            step();
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("vec%0d_p%0d", i, k),
                    rd_data[k*32 +: 32], vt[i].ex[k]);
            end
        end
        idle_wr();

        // x0 handling in both flavours
        wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFFFFFF;
        rd_addr = '0;
        step();
        idle_wr();
        chk("x0_byp_zr1", rd_data[31:0], 0);
        chk("x0_byp_zr0", rd_data_z[31:0], 32'hFFFFFFFF);
        step();
        chk("x0_read_zr1", rd_data[31:0], 0);
        chk("x0_read_zr0", rd_data_z[31:0], 32'hFFFFFFFF);

        // Write during clear is dropped
        wr0_en = 1; wr0_addr = 3; wr0_data = 32'hAA;
        step();
        idle_wr();
        rd_addr = {15'd0, 5'd3};
        step();
        chk("fill3", rd_data[31:0], 32'hAA);
        clear_req = 1;
        step();
        clear_req = 0;
        chk("clr_busy1", 32'(busy), 1);
        step();
        chk("clr_busy2", 32'(busy), 1);
        wr0_en = 1; wr0_addr = 3; wr0_data = 32'hBB;
        step();
        idle_wr();
        chk("clr_rd_held", rd_data[31:0], 0);
        count_busy(c, 0);
        chk("clr_len_rest", c, 30);
        step();
        chk("after_clear3", rd_data[31:0], 0);

        // Reset mid-clear restarts the full sweep; clear_req inside is ignored
        clear_req = 1;
        step();
        clear_req = 0;
        for (int i = 0; i < 10; i++) step();
        rst = 1;
        step();
        rst = 0;
        count_busy(c, 1);
        chk("rst_midclear_len", c, 32);
        rd_addr = {5'd9, 5'd7, 5'd5, 5'd3};
        step();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("final_p%0d", k), rd_data[k*32 +: 32], 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
